// File: rtl/run_control_pkg.sv
// Shared types and default widths for the run/halt/step sequencer.
package run_control_pkg;

    localparam int RC_PC_VALUE_WIDTH  = 5;
    localparam int RC_STEP_CNT_WIDTH  = 8;
    localparam int RC_CYCLE_CNT_WIDTH = 16;

    // 2'b11 is unused; the sequencer steers it back to RC_HALTED.
    typedef enum logic [1:0] {
        RC_HALTED = 2'b00,
        RC_RUN    = 2'b01,
        RC_STEP   = 2'b10
    } run_state_t;

endpackage

// File: rtl/run_control_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] value_o
);

    logic [WIDTH-1:0] count_q, count_d;

    // Next count: clear first, otherwise increment until all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (inc_i && (count_q != {WIDTH{1'b1}}))
            count_d = count_q + 1'b1;
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign value_o = count_q;

endmodule

// File: rtl/run_control.sv
// Run/halt/step sequencer: gates the core's write enables and PC advance.
// Optional retired-instruction counter: RUN_CONTROL_CYCLE_COUNTER_EN.
module run_control
    import run_control_pkg::*;
#(
    parameter int PC_VALUE_WIDTH  = RC_PC_VALUE_WIDTH,
    parameter int STEP_CNT_WIDTH  = RC_STEP_CNT_WIDTH,
    parameter int CYCLE_CNT_WIDTH = RC_CYCLE_CNT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run_req,
    input  logic                       halt_req,
    input  logic                       step_req,
    input  logic [STEP_CNT_WIDTH-1:0]  step_count,
    input  logic                       bp_enable,
    input  logic [PC_VALUE_WIDTH-1:0]  bp_addr,
    input  logic [PC_VALUE_WIDTH-1:0]  pc_value,
    input  logic                       id_RF_we,
    input  logic                       id_MEM_we,
    input  logic                       id_A_we,
    input  logic                       id_jump_enable,
    input  logic                       cnt_clr,
    output logic                       pc_enable,
    output logic                       RF_we,
    output logic                       MEM_we,
    output logic                       A_we,
    output logic                       PC_jump_enable,
    output logic                       halted,
    output logic                       bp_hit,
    output logic [CYCLE_CNT_WIDTH-1:0] cycle_count
);

    run_state_t                state_q, state_d;
    logic [STEP_CNT_WIDTH-1:0] remaining_q, remaining_d;
    logic                      first_q, first_d;
    logic                      bp_hit_q, bp_hit_d;
    logic                      bp_stop, exec;

    // first_q masks the breakpoint for one cycle so a resume executes it.
    assign bp_stop = bp_enable && (pc_value == bp_addr) && !first_q;
    assign exec    = ((state_q == RC_RUN) || (state_q == RC_STEP)) && !bp_stop;

    assign pc_enable      = exec;
    assign RF_we          = id_RF_we       & exec;
    assign MEM_we         = id_MEM_we      & exec;
    assign A_we           = id_A_we        & exec;
    assign PC_jump_enable = id_jump_enable & exec;
    assign halted         = (state_q == RC_HALTED);
    assign bp_hit         = bp_hit_q;

    // Next-state logic: request decode in HALTED, stop conditions in RUN/STEP.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        first_d     = 1'b0;
        bp_hit_d    = bp_hit_q;
        unique case (state_q)
            RC_HALTED: begin
                if (halt_req) begin
                    state_d = RC_HALTED;
                end else if (step_req) begin
                    state_d     = RC_STEP;
                    remaining_d = (step_count == '0) ? STEP_CNT_WIDTH'(1) : step_count;
                    first_d     = 1'b1;
                    bp_hit_d    = 1'b0;
                end else if (run_req) begin
                    state_d  = RC_RUN;
                    first_d  = 1'b1;
                    bp_hit_d = 1'b0;
                end
            end
            RC_RUN: begin
                if (bp_stop) begin
                    state_d  = RC_HALTED;
                    bp_hit_d = 1'b1;
                end else if (halt_req) begin
                    state_d = RC_HALTED;
                end
            end
            RC_STEP: begin
                if (bp_stop) begin
                    state_d     = RC_HALTED;
                    bp_hit_d    = 1'b1;
                    remaining_d = '0;
                end else begin
                    remaining_d = remaining_q - 1'b1;
                    if (halt_req || (remaining_q <= STEP_CNT_WIDTH'(1))) begin
                        state_d     = RC_HALTED;
                        remaining_d = '0;
                    end
                end
            end
            default: begin
                state_d     = RC_HALTED;
                remaining_d = '0;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RC_HALTED;
            remaining_q <= '0;
            first_q     <= 1'b0;
            bp_hit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
            bp_hit_q    <= bp_hit_d;
        end
    end

`ifdef RUN_CONTROL_CYCLE_COUNTER_EN
    sat_counter #(.WIDTH(CYCLE_CNT_WIDTH)) u_cycle_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr),
        .inc_i   (exec),
        .value_o (cycle_count)
    );
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign cycle_count    = '0;
`endif

endmodule

// File: tb/tb_run_control.sv
// Directed bench for run_control with a queue-based scoreboard.
module tb_run_control;

    localparam int PW = 5;
    localparam int SW = 8;
    localparam int CW = 16;
`ifdef RUN_CONTROL_CYCLE_COUNTER_EN
    localparam bit CC_EN = 1'b1;
`else
    localparam bit CC_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run_req = 0, halt_req = 0, step_req = 0, cnt_clr = 0;
    logic [SW-1:0] step_count = '0;
    logic          bp_enable = 0;
    logic [PW-1:0] bp_addr = '0, pc_value = '0;
    logic [3:0]    id = 4'b1111;  // {RF, MEM, A, JUMP}
    logic          pc_enable, RF_we, MEM_we, A_we, PC_jump_enable, halted, bp_hit;
    logic [CW-1:0] cycle_count;

    typedef struct {
        string         nm;
        logic          pe;
        logic [3:0]    we;
        logic          h;
        logic          b;
        logic [CW-1:0] cc;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nmis = 0;

    run_control #(.PC_VALUE_WIDTH(PW), .STEP_CNT_WIDTH(SW), .CYCLE_CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
        .step_count(step_count), .bp_enable(bp_enable), .bp_addr(bp_addr), .pc_value(pc_value),
        .id_RF_we(id[3]), .id_MEM_we(id[2]), .id_A_we(id[1]), .id_jump_enable(id[0]),
        .cnt_clr(cnt_clr), .pc_enable(pc_enable), .RF_we(RF_we), .MEM_we(MEM_we), .A_we(A_we),
        .PC_jump_enable(PC_jump_enable), .halted(halted), .bp_hit(bp_hit), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic push(input string nm, input bit e_pe, input bit e_h, input bit e_b,
                        input logic [CW-1:0] e_cc);
        exp_t e;
        e.nm = nm;
        e.pe = e_pe;
        e.we = id & {4{e_pe}};
        e.h  = e_h;
        e.b  = e_b;
        e.cc = CC_EN ? e_cc : '0;
        q.push_back(e);
    endtask

    // One cycle: entered at a posedge, drives at +1, expectation checked at the negedge.
    task automatic v(input string nm, input bit r, input bit h, input bit s,
                     input logic [SW-1:0] sc, input logic [PW-1:0] pc, input bit clr,
                     input bit e_pe, input bit e_h, input bit e_b, input logic [CW-1:0] e_cc);
        #1;
        rst = 0; run_req = r; halt_req = h; step_req = s; step_count = sc;
        pc_value = pc; cnt_clr = clr;
        push(nm, e_pe, e_h, e_b, e_cc);
        @(posedge clk);
    endtask

    // Reset asserted mid-cycle; outputs must drop before any clock edge.
    task automatic rv(input string nm);
        #1;
        rst = 1;
        push(nm, 1'b0, 1'b1, 1'b0, '0);
        @(posedge clk);
    endtask

    // Monitor: pops one expectation per cycle and compares.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                nvec++;
                if (pc_enable !== e.pe || {RF_we, MEM_we, A_we, PC_jump_enable} !== e.we ||
                    halted !== e.h || bp_hit !== e.b || cycle_count !== e.cc) begin
                    nmis++;
                    $display("FAIL %s: got pe=%b we=%b halted=%b bp=%b cc=%h, want pe=%b we=%b halted=%b bp=%b cc=%h",
                             e.nm, pc_enable, {RF_we, MEM_we, A_we, PC_jump_enable}, halted, bp_hit,
                             cycle_count, e.pe, e.we, e.h, e.b, e.cc);
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        rv("reset_state");
        id = 4'b0010;
        for (int i = 0; i < 10; i++) v("idle", 0,0,0,0,0,0, 0,1,0,0);
        id = 4'b1111;

        v("run_req", 1,0,0,0,0,0, 0,1,0,0);
        for (int i = 0; i < 5; i++) v("run_pc", 0,0,0,0,PW'(i),0, 1,0,0,CW'(i));
        v("halt_pc5",     0,1,0,0,5,0, 1,0,0,5);
        v("halted_after", 0,0,0,0,5,0, 0,1,0,6);

        bp_enable = 1; bp_addr = 7;
        v("bp_run_req", 1,0,0,0,0,0, 0,1,0,6);
        for (int i = 0; i < 7; i++) v("bp_run", 0,0,0,0,PW'(i),0, 1,0,0,CW'(6+i));
        v("bp_stop",          0,0,0,0,7,0, 0,0,0,13);
        v("bp_halted",        0,0,0,0,7,0, 0,1,1,13);
        v("bp_resume_req",    1,0,0,0,7,0, 0,1,1,13);
        v("bp_resume_exec",   0,0,0,0,7,0, 1,0,0,13);
        v("bp_resume_halt",   0,1,0,0,8,0, 1,0,0,14);
        v("bp_resume_halted", 0,0,0,0,8,0, 0,1,0,15);
        bp_enable = 0;

        v("step3_req", 0,0,1,3,8,0, 0,1,0,15);
        for (int i = 0; i < 3; i++) v("step3", 0,0,0,0,PW'(8+i),0, 1,0,0,CW'(15+i));
        v("step3_done",   0,0,0,0,11,0, 0,1,0,18);
        v("step0_req",    0,0,1,0,11,0, 0,1,0,18);
        v("step0",        0,0,0,0,11,0, 1,0,0,18);
        v("step0_done",   0,0,0,0,12,0, 0,1,0,19);
        v("all_req",      1,1,1,5,12,0, 0,1,0,19);
        v("all_req_held", 0,0,0,0,12,0, 0,1,0,19);
        v("step_run_req", 1,0,1,2,12,0, 0,1,0,19);
        v("step2_run_ign",1,0,0,0,12,0, 1,0,0,19);
        v("step2",        0,0,0,0,13,0, 1,0,0,20);
        v("step2_done",   0,0,0,0,14,0, 0,1,0,21);

        bp_enable = 1; bp_addr = 24;
        v("step10_req", 0,0,1,10,20,0, 0,1,0,21);
        for (int i = 0; i < 4; i++) v("step10", 0,0,0,0,PW'(20+i),0, 1,0,0,CW'(21+i));
        v("step10_bp",        0,0,0,0,24,0, 0,0,0,25);
        v("step10_bp_halted", 0,0,0,0,24,0, 0,1,1,25);
        v("step5_req",        0,0,1,5,24,0, 0,1,1,25);
        v("step5_first",      0,0,0,0,24,0, 1,0,0,25);
        v("bp_and_halt",      0,1,0,0,24,0, 0,0,0,26);
        v("bp_and_halt_done", 0,0,0,0,24,0, 0,1,1,26);
        v("stays_halted",     0,0,0,0,25,0, 0,1,1,26);
        bp_enable = 0;

        v("clr_run_req", 1,0,0,0,0,0, 0,1,1,26);
        v("clr_exec",    0,0,0,0,0,1, 1,0,0,26);
        v("after_clr",   0,0,0,0,1,0, 1,0,0,0);
        v("clr_halt",    0,1,0,0,2,0, 1,0,0,1);
        v("clr_halted",  0,0,0,0,2,1, 0,1,0,2);
        v("clr_idle",    0,0,0,0,2,0, 0,1,0,0);

        v("rst_step_req", 0,0,1,10,3,0, 0,1,0,0);
        v("rst_step",     0,0,0,0,3,0, 1,0,0,0);
        v("rst_step",     0,0,0,0,4,0, 1,0,0,1);
        rv("async_rst_mid_step");
        v("post_rst",     0,0,0,0,5,0, 0,1,0,0);

`ifdef RUN_CONTROL_CYCLE_COUNTER_EN
        v("sat_run_req", 1,0,0,0,0,0, 0,1,0,0);
        #1 run_req = 0;
        repeat (65534) @(posedge clk);
        v("sat_fffe",   0,0,0,0,0,0, 1,0,0,16'hFFFE);
        v("sat_ffff",   0,0,0,0,1,0, 1,0,0,16'hFFFF);
        v("sat_hold",   0,1,0,0,2,0, 1,0,0,16'hFFFF);
        v("sat_halted", 0,0,0,0,2,0, 0,1,0,16'hFFFF);
`endif

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            nmis++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
